// File: rtl/smpl_queue_seq.sv
// smpl_queue_seq
// Stereo sample queue and sequencer for the FIR band filters. Incoming
// 16-bit left/right samples go into a DEPTH-entry circular buffer. Once
// TAPS samples have been received, every new sample starts a stream of the
// most recent TAPS samples (oldest first, one per clock) with `sequencing`
// high for exactly that stream.
//
// Configuration macro: SMPL_QUEUE_PEND_EN
//   defined   - a strobe during a stream is stored and queues one more
//               stream (pending); a strobe while pending is set pulses
//               overrun but is still stored.
//   undefined - a strobe during a stream is dropped and pulses overrun.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   wrt_smpl   in   one-cycle strobe, new sample on lft_smpl/rght_smpl
//   lft_smpl   in   [15:0] left sample (signed)
//   rght_smpl  in   [15:0] right sample (signed)
//   sequencing out  high while lft_out/rght_out carry a streamed sample
//   lft_out    out  [15:0] streamed left sample (holds when idle)
//   rght_out   out  [15:0] streamed right sample (holds when idle)
//   full       out  at least TAPS samples received since reset (sticky)
//   overrun    out  one-cycle pulse, a strobe could not be scheduled
module smpl_queue_seq #(
    parameter int DEPTH = 1024,
    parameter int TAPS  = 1021
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt_smpl,
    input  logic [15:0] lft_smpl,
    input  logic [15:0] rght_smpl,
    output logic        sequencing,
    output logic [15:0] lft_out,
    output logic [15:0] rght_out,
    output logic        full,
    output logic        overrun
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(TAPS + 1);
    localparam logic [PTR_W-1:0] TAPS_P   = PTR_W'(TAPS);
    localparam logic [PTR_W-1:0] LAST_RD  = PTR_W'(TAPS - 1);
    localparam logic [CNT_W-1:0] TAPS_C   = CNT_W'(TAPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAPS - 1);

    typedef enum logic [1:0] {FILL, IDLE, READ, GAP} state_t;

    state_t           state, state_nxt;
    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0] rd_cnt, rd_start, rd_addr;
    logic [CNT_W-1:0] cnt;
    logic             busy, wr_acc, ovr_nxt, seq_again, start_load;

    assign busy       = (state == READ) || (state == GAP);
    assign wr_ptr_nxt = wr_acc ? wr_ptr + 1'b1 : wr_ptr;
    assign rd_addr    = rd_start + rd_cnt;
    assign full       = (cnt == TAPS_C);

`ifdef SMPL_QUEUE_PEND_EN
    logic pending, pend_nxt;

    // Strobes are always stored. One arriving mid-stream queues a single
    // further stream; a second one before that stream starts is reported
    // as overrun because both collapse into the same pending stream.
    always_comb begin
        wr_acc    = wrt_smpl;
        ovr_nxt   = wrt_smpl && busy && pending;
        seq_again = pending || wrt_smpl;
        pend_nxt  = pending;
        if (state == GAP)
            pend_nxt = 1'b0;
        else if (wrt_smpl && busy)
            pend_nxt = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pending <= 1'b0;
        else
            pending <= pend_nxt;
    end
`else
    // Strobes arriving mid-stream are discarded entirely so the buffer
    // never advances underneath a stream.
    always_comb begin
        wr_acc    = wrt_smpl && !busy;
        ovr_nxt   = wrt_smpl && busy;
        seq_again = 1'b0;
    end
`endif

    // Next-state logic for the fill / idle / stream / gap sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if (wr_acc && (cnt == CNT_LAST)) state_nxt = READ;
            IDLE: if (wrt_smpl) state_nxt = READ;
            READ: if (rd_cnt == LAST_RD) state_nxt = GAP;
            GAP:  state_nxt = seq_again ? READ : IDLE;
            default: state_nxt = FILL;
        endcase
    end

    // The window start is captured when a stream begins, from the
    // post-write pointer, so it always ends at the newest stored sample.
    assign start_load = (state_nxt == READ) && (state != READ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            wr_ptr     <= '0;
            cnt        <= '0;
            rd_cnt     <= '0;
            rd_start   <= '0;
            sequencing <= 1'b0;
            lft_out    <= '0;
            rght_out   <= '0;
            overrun    <= 1'b0;
        end else begin
            state   <= state_nxt;
            wr_ptr  <= wr_ptr_nxt;
            overrun <= ovr_nxt;
            if (wr_acc && (cnt != TAPS_C))
                cnt <= cnt + 1'b1;
            if (start_load)
                rd_start <= wr_ptr_nxt - TAPS_P;
            if (state == READ)
                rd_cnt <= (rd_cnt == LAST_RD) ? '0 : rd_cnt + 1'b1;
            // Output registers double as the synchronous memory read
            // port, hence data lags the address by one cycle.
            sequencing <= (state == READ);
            if (state == READ)
                {lft_out, rght_out} <= mem[rd_addr];
        end
    end

    // Sample storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= {lft_smpl, rght_smpl};
    end

endmodule
